// File: rtl/ysyx_041461_defines.sv
// Shared encodings for the AXI read arbiter: FSM states and AXI RESP codes.
package ysyx_041461_defines;

    typedef enum logic [1:0] {
        ysyx_041461_ARB_IDLE = 2'd0,
        ysyx_041461_ARB_AR   = 2'd1,
        ysyx_041461_ARB_R    = 2'd2
    } ysyx_041461_arb_state_e;

    localparam logic [1:0] ysyx_041461_RESP_OKAY   = 2'b00;
    localparam logic [1:0] ysyx_041461_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] ysyx_041461_RESP_SLVERR = 2'b10;
    localparam logic [1:0] ysyx_041461_RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_041461_arb_pick.sv
// Combinational 2-way picker. YSYX_041461_ARB_ROUND_ROBIN_EN selects round-robin
// on a tie; otherwise master 1 (LSU) always wins a tie.
module ysyx_041461_arb_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       win
);

`ifdef YSYX_041461_ARB_ROUND_ROBIN_EN
    always_comb begin
        win = req[1];
        if (&req)
            win = ~last_grant;
    end
`else
    // Fixed priority ignores history and only needs to know whether master 1 asks.
    logic w_unused;
    assign w_unused = &{1'b0, last_grant, req[0]};
    assign win      = req[1];
`endif

endmodule

// File: rtl/ysyx_041461_axi_rd_arbiter.sv
// Two-master AXI4 read arbiter (IFU = m0, LSU = m1), one transaction in flight.
// Tie policy chosen by YSYX_041461_ARB_ROUND_ROBIN_EN (default: fixed, LSU wins).
module ysyx_041461_axi_rd_arbiter
    import ysyx_041461_defines::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_arvalid,
    input  logic [31:0] m0_araddr,
    input  logic [3:0]  m0_arid,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic [1:0]  m0_arburst,
    output logic        m0_arready,
    input  logic        m0_rready,
    output logic        m0_rvalid,
    output logic [63:0] m0_rdata,
    output logic [3:0]  m0_rid,
    output logic [1:0]  m0_rresp,
    output logic        m0_rlast,

    input  logic        m1_arvalid,
    input  logic [31:0] m1_araddr,
    input  logic [3:0]  m1_arid,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic [1:0]  m1_arburst,
    output logic        m1_arready,
    input  logic        m1_rready,
    output logic        m1_rvalid,
    output logic [63:0] m1_rdata,
    output logic [3:0]  m1_rid,
    output logic [1:0]  m1_rresp,
    output logic        m1_rlast,

    output logic        s_arvalid,
    output logic [31:0] s_araddr,
    output logic [3:0]  s_arid,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    input  logic        s_arready,
    input  logic        s_rvalid,
    input  logic [63:0] s_rdata,
    input  logic [3:0]  s_rid,
    input  logic [1:0]  s_rresp,
    input  logic        s_rlast,
    output logic        s_rready
);

    ysyx_041461_arb_state_e r_state, w_state_nxt;
    logic        r_grant, w_grant_nxt;
    logic [1:0]  w_req;
    logic        w_win;
    logic        w_last_grant;

    logic        w_g_arvalid;
    logic [31:0] w_g_araddr;
    logic [3:0]  w_g_arid;
    logic [7:0]  w_g_arlen;
    logic [2:0]  w_g_arsize;
    logic [1:0]  w_g_arburst;
    logic        w_g_rready;

    assign w_req = {m1_arvalid, m0_arvalid};

    ysyx_041461_arb_pick u_pick (
        .req        (w_req),
        .last_grant (w_last_grant),
        .win        (w_win)
    );

`ifdef YSYX_041461_ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_grant <= 1'b1;
        else if (r_state == ysyx_041461_ARB_IDLE && |w_req)
            r_last_grant <= w_win;
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = 1'b0;
`endif

    // Granted master's request/accept, selected once so the FSM stays symmetric.
    assign w_g_arvalid = r_grant ? m1_arvalid : m0_arvalid;
    assign w_g_araddr  = r_grant ? m1_araddr  : m0_araddr;
    assign w_g_arid    = r_grant ? m1_arid    : m0_arid;
    assign w_g_arlen   = r_grant ? m1_arlen   : m0_arlen;
    assign w_g_arsize  = r_grant ? m1_arsize  : m0_arsize;
    assign w_g_arburst = r_grant ? m1_arburst : m0_arburst;
    assign w_g_rready  = r_grant ? m1_rready  : m0_rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ysyx_041461_ARB_IDLE;
            r_grant <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;

        s_arvalid  = 1'b0;
        s_araddr   = 32'd0;
        s_arid     = 4'd0;
        s_arlen    = 8'd0;
        s_arsize   = 3'd0;
        s_arburst  = 2'd0;
        s_rready   = 1'b0;

        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = 64'd0;
        m0_rid     = 4'd0;
        m0_rresp   = ysyx_041461_RESP_OKAY;
        m0_rlast   = 1'b0;

        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = 64'd0;
        m1_rid     = 4'd0;
        m1_rresp   = ysyx_041461_RESP_OKAY;
        m1_rlast   = 1'b0;

        case (r_state)
            ysyx_041461_ARB_IDLE: begin
                if (|w_req) begin
                    w_state_nxt = ysyx_041461_ARB_AR;
                    w_grant_nxt = w_win;
                end
            end

            ysyx_041461_ARB_AR: begin
                s_arvalid = w_g_arvalid;
                s_araddr  = w_g_araddr;
                s_arid    = w_g_arid;
                s_arlen   = w_g_arlen;
                s_arsize  = w_g_arsize;
                s_arburst = w_g_arburst;
                if (r_grant)
                    m1_arready = s_arready;
                else
                    m0_arready = s_arready;
                if (w_g_arvalid && s_arready)
                    w_state_nxt = ysyx_041461_ARB_R;
            end

            ysyx_041461_ARB_R: begin
                s_rready = w_g_rready;
                if (r_grant) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rid    = s_rid;
                    m1_rresp  = s_rresp;
                    m1_rlast  = s_rlast;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rid    = s_rid;
                    m0_rresp  = s_rresp;
                    m0_rlast  = s_rlast;
                end
                // Only the rlast handshake ends the burst; arlen is never counted.
                if (s_rvalid && w_g_rready && s_rlast)
                    w_state_nxt = ysyx_041461_ARB_IDLE;
            end

            default: w_state_nxt = ysyx_041461_ARB_IDLE;
        endcase
    end

endmodule
